// File: rtl/decodificador_teclado_param.sv
`timescale 1ns/1ps
// Purpose: scans an active-low key matrix, debounces press and release, decodes keys
//          and accumulates digits into a PIN buffer; emits submit/cancel/timeout messages.
// Latency: key detected in SCAN at cycle D gives APPLY at D+T_DEB and EMIT at D+T_DEB+1.
// Backpressure: none; tecla_valid/digitos_valid are single-cycle pulses the consumer must take.
// Ports: clk/rst (async active-high), enable (sync idle-and-clear), col_matriz (column sense),
//        lin_matriz (one-cold row drive), tecla_value/tecla_valid (accepted key),
//        digitos_value/digitos_valid (live buffer or message), contagem, overflow.
module decodificador_teclado_param #(
  parameter int N_LIN     = 4,
  parameter int N_COL     = 4,
  parameter int N_DIG     = 20,
  parameter int T_DEB     = 50,
  parameter int T_TIMEOUT = 5000,
  parameter int SCAN_DIV  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_COL-1:0]           col_matriz,
  output logic [N_LIN-1:0]           lin_matriz,
  output logic [3:0]                 tecla_value,
  output logic                       tecla_valid,
  output logic [4*N_DIG-1:0]         digitos_value,
  output logic                       digitos_valid,
  output logic [$clog2(N_DIG+1)-1:0] contagem,
  output logic                       overflow
);

  localparam int RW  = $clog2(N_LIN);
  localparam int CIW = $clog2(N_COL);
  localparam int CW  = $clog2(N_DIG+1);
  localparam int DW  = $clog2(T_DEB+1);
  localparam int TW  = $clog2(T_TIMEOUT+1);
  localparam int SW  = $clog2(SCAN_DIV+1);

  localparam logic [DW-1:0]      DEB_LAST = DW'(T_DEB);
  localparam logic [TW-1:0]      TMO_MAX  = TW'(T_TIMEOUT);
  localparam logic [SW-1:0]      DIV_LAST = SW'(SCAN_DIV-1);
  localparam logic [RW-1:0]      ROW_LAST = RW'(N_LIN-1);
  localparam logic [CW-1:0]      CNT_FULL = CW'(N_DIG);
  localparam logic [4*N_DIG-1:0] ALL_F    = {N_DIG{4'hF}};
  localparam logic [4*N_DIG-1:0] ALL_B    = {N_DIG{4'hB}};
  localparam logic [4*N_DIG-1:0] ALL_E    = {N_DIG{4'hE}};

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DEB, S_APPLY, S_EMIT, S_REL} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d, row_nxt;
  logic [SW-1:0]        div_q, div_d;
  logic [CIW-1:0]       col_q, col_d;
  logic [DW-1:0]        deb_q, deb_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [4*N_DIG-1:0]   buf_q, buf_d;
  logic [4*N_DIG-1:0]   msg_q, msg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [3:0]           key_q, key_d;
  logic                 ret_q, ret_d;   // EMIT came from a timeout: resume SCAN, skip RELEASE
  logic                 low_seen, low_multi, one_low, col_match;
  logic [CIW-1:0]       low_idx;

  function automatic logic [3:0] decode(input logic [RW-1:0] r, input logic [CIW-1:0] c);
    int ri;
    int ci;
    ri = int'(r);
    ci = int'(c);
    if (ri >= 4)       decode = 4'hF;
    else if (ci == 3)  decode = (ri == 0) ? 4'hC : (ri == 1) ? 4'hD : 4'hF;
    else if (ri == 3)  decode = (ci == 0) ? 4'hA : (ci == 1) ? 4'h0 : 4'hB;
    else               decode = 4'(ri * 3 + ci + 1);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      div_q   <= '0;
      col_q   <= '0;
      deb_q   <= '0;
      tmo_q   <= '0;
      buf_q   <= ALL_F;
      msg_q   <= ALL_F;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      key_q   <= 4'hF;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      div_q   <= div_d;
      col_q   <= col_d;
      deb_q   <= deb_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      key_q   <= key_d;
      ret_q   <= ret_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    div_d   = div_q;
    col_d   = col_q;
    deb_d   = deb_q;
    tmo_d   = tmo_q;
    buf_d   = buf_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    key_d   = key_q;
    ret_d   = ret_q;

    // A valid press is exactly one low column; comparing the index is
    // equivalent to comparing against the latched column vector.
    low_seen  = 1'b0;
    low_multi = 1'b0;
    low_idx   = '0;
    for (int c = 0; c < N_COL; c++) begin
      if (!col_matriz[c]) begin
        low_multi = low_multi | low_seen;
        low_seen  = 1'b1;
        low_idx   = CIW'(c);
      end
    end
    one_low   = low_seen & ~low_multi;
    col_match = one_low && (low_idx == col_q);
    row_nxt   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

    // Inactivity timer saturates so a timeout reached in DEBOUNCE/RELEASE
    // is still pending when SCAN is re-entered.
    if (state_q == S_SCAN || state_q == S_DEB || state_q == S_REL) begin
      if (cnt_q == '0)           tmo_d = '0;
      else if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        buf_d = ALL_F;
        cnt_d = '0;
        ovf_d = 1'b0;
        tmo_d = '0;
        if (enable) begin
          state_d = S_SCAN;
          row_d   = '0;
          div_d   = '0;
        end
      end
      S_SCAN: begin
        if (tmo_q == TMO_MAX) begin
          state_d = S_EMIT;
          msg_d   = ALL_E;
          ret_d   = 1'b1;
        end else if (one_low) begin
          col_d = low_idx;
          if (DEB_LAST <= DW'(1)) begin
            state_d = S_APPLY;
            key_d   = decode(row_q, low_idx);
          end else begin
            state_d = S_DEB;
            deb_d   = DW'(1);
          end
        end else if (div_q == DIV_LAST) begin
          row_d = row_nxt;
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DEB: begin
        if (col_match) begin
          if (deb_q + 1'b1 == DEB_LAST) begin
            state_d = S_APPLY;
            key_d   = decode(row_q, col_q);
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          state_d = S_SCAN;
          row_d   = row_nxt;
          div_d   = '0;
        end
      end
      S_APPLY: begin
        tmo_d   = '0;
        deb_d   = '0;
        state_d = S_REL;
        ret_d   = 1'b0;
        if (key_q <= 4'h9) begin
          if (cnt_q < CNT_FULL) begin
            buf_d      = buf_q << 4;
            buf_d[3:0] = key_q;
            cnt_d      = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (key_q == 4'hC) begin
          ovf_d = 1'b0;
          if (cnt_q != '0) begin
            buf_d                 = buf_q >> 4;
            buf_d[4*N_DIG-1 -: 4] = 4'hF;
            cnt_d                 = cnt_q - 1'b1;
          end
        end else if (key_q == 4'hD) begin
          buf_d = ALL_F;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (key_q == 4'hA) begin
          state_d = S_EMIT;
          msg_d   = buf_q;
        end else if (key_q == 4'hB) begin
          state_d = S_EMIT;
          msg_d   = ALL_B;
        end
      end
      S_EMIT: begin
        buf_d = ALL_F;
        cnt_d = '0;
        ovf_d = 1'b0;
        tmo_d = '0;
        deb_d = '0;
        div_d = '0;
        state_d = ret_q ? S_SCAN : S_REL;
      end
      S_REL: begin
        if (&col_matriz) begin
          if (deb_q + 1'b1 == DEB_LAST) begin
            state_d = S_SCAN;
            row_d   = row_nxt;
            div_d   = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      buf_d   = ALL_F;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      tmo_d   = '0;
    end
  end

  // Moore output decode
  always_comb begin
    for (int r = 0; r < N_LIN; r++) begin
      lin_matriz[r] = !((state_q != S_IDLE) && (row_q == RW'(r)));
    end
    tecla_valid   = (state_q == S_APPLY);
    tecla_value   = key_q;
    digitos_valid = (state_q == S_EMIT);
    digitos_value = (state_q == S_EMIT) ? msg_q : buf_q;
    contagem      = cnt_q;
    overflow      = ovf_q;
  end

endmodule

// File: tb/tb_decodificador_teclado_param.sv
`timescale 1ns/1ps
module tb_decodificador_teclado_param;

  localparam int NL = 4;
  localparam int NC = 4;
  localparam int ND = 4;
  localparam int TD = 3;
  localparam int TT = 40;
  localparam int SD = 1;
  localparam int CW = $clog2(ND+1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic [NC-1:0]   col_matriz;
  logic [NL-1:0]   lin_matriz;
  logic [3:0]      tecla_value;
  logic            tecla_valid;
  logic [4*ND-1:0] digitos_value;
  logic            digitos_valid;
  logic [CW-1:0]   contagem;
  logic            overflow;

  logic [NL*NC-1:0] press_map = '0;
  logic [NC-1:0]    raw_low = '0;
  logic [NC-1:0]    col_lo;

  int checks = 0;
  int errors = 0;
  int key_count = 0;
  int emit_count = 0;
  int since_apply = 0;
  logic [4*ND-1:0] last_msg = '0;

  // Reference model: digits held newest-last, plus overflow and pending message
  logic [3:0]      mq[$];
  logic [3:0]      expq[$];
  logic            movf = 1'b0;
  logic            pend = 1'b0;
  logic [4*ND-1:0] pend_msg = '0;

  logic [3:0] keymap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hC},
                                '{4'h4, 4'h5, 4'h6, 4'hD},
                                '{4'h7, 4'h8, 4'h9, 4'hF},
                                '{4'hA, 4'h0, 4'hB, 4'hF}};

  decodificador_teclado_param #(
    .N_LIN(NL), .N_COL(NC), .N_DIG(ND), .T_DEB(TD), .T_TIMEOUT(TT), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .col_matriz(col_matriz),
    .lin_matriz(lin_matriz), .tecla_value(tecla_value), .tecla_valid(tecla_valid),
    .digitos_value(digitos_value), .digitos_valid(digitos_valid),
    .contagem(contagem), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_lo = raw_low;
    for (int r = 0; r < NL; r++)
      for (int c = 0; c < NC; c++)
        if (!lin_matriz[r] && press_map[r*NC+c]) col_lo[c] = 1'b1;
    col_matriz = ~col_lo;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*ND-1:0] img();
    logic [4*ND-1:0] v;
    v = {ND{4'hF}};
    for (int i = 0; i < mq.size(); i++) v[4*i +: 4] = mq[mq.size()-1-i];
    return v;
  endfunction

  task automatic model_clear();
    mq.delete();
    movf = 1'b0;
  endtask

  task automatic model_apply(input logic [3:0] k);
    if (k <= 4'h9) begin
      if (mq.size() < ND) mq.push_back(k);
      else movf = 1'b1;
    end else if (k == 4'hC) begin
      if (mq.size() > 0) void'(mq.pop_back());
      movf = 1'b0;
    end else if (k == 4'hD) begin
      model_clear();
    end else if (k == 4'hA) begin
      pend = 1'b1;
      pend_msg = img();
    end else if (k == 4'hB) begin
      pend = 1'b1;
      pend_msg = {ND{4'hB}};
    end
  endtask

  // Compare process: every cycle against the model
  initial begin
    logic [3:0] k;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_clear();
        pend = 1'b0;
        since_apply = 0;
      end else begin
        check("dual_pulse", {1'b0, tecla_valid & digitos_valid}, 0);
        check("row_one_cold", ($countones(~lin_matriz) <= 1), 1);
        check("contagem", contagem, mq.size());
        check("overflow", overflow, movf);
        if (pend) check("emit_pulse", digitos_valid, 1);
        if (digitos_valid) begin
          emit_count++;
          last_msg = digitos_value;
          if (pend) begin
            check("emit_msg", digitos_value, pend_msg);
          end else begin
            check("timeout_msg", digitos_value, {ND{4'hE}});
            check("timeout_nonempty", mq.size() > 0, 1);
            check("timeout_delay", since_apply >= TT, 1);
          end
        end else begin
          check("digitos_value", digitos_value, img());
        end
        if (digitos_valid || pend) begin
          pend = 1'b0;
          model_clear();
        end
        if (tecla_valid) begin
          key_count++;
          since_apply = 0;
          check("key_expected", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            k = expq.pop_front();
            check("tecla_value", tecla_value, k);
            model_apply(k);
          end
        end
        if (!enable) begin
          model_clear();
          pend = 1'b0;
        end
        if (since_apply < 100000) since_apply++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_rc(input int r, input int c, input int hold, input int gap);
    expq.push_back(keymap[r][c]);
    press_map[r*NC+c] = 1'b1;
    cyc(hold);
    press_map[r*NC+c] = 1'b0;
    cyc(gap);
  endtask

  task automatic press_code(input logic [3:0] code, input int hold);
    int fr;
    int fc;
    fr = -1;
    fc = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (fr < 0 && keymap[r][c] == code) begin
          fr = r;
          fc = c;
        end
    press_rc(fr, fc, hold, 8);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int e0;
    int ri;
    int ci;
    bit found;

    // Reset values
    cyc(3);
    check("rst_lin", lin_matriz, 4'hF);
    check("rst_tecla_value", tecla_value, 4'hF);
    check("rst_tecla_valid", tecla_valid, 0);
    check("rst_digitos_valid", digitos_valid, 0);
    check("rst_digitos_value", digitos_value, 16'hFFFF);
    check("rst_contagem", contagem, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    cyc(5);

    // Entry and submit
    k0 = key_count; e0 = emit_count;
    press_code(4'h1, 12); press_code(4'h2, 12); press_code(4'h3, 12); press_code(4'hA, 12);
    cyc(2);
    check("submit_keys", key_count - k0, 4);
    check("submit_emits", emit_count - e0, 1);
    check("submit_msg", last_msg, 16'hF123);
    check("submit_cleared", digitos_value, 16'hFFFF);
    check("submit_count", contagem, 0);

    // Overflow and backspace
    for (int d = 1; d <= 5; d++) press_code(4'(d), 12);
    check("ovf_buffer", digitos_value, 16'h1234);
    check("ovf_flag", overflow, 1);
    check("ovf_count", contagem, 4);
    press_code(4'hC, 12);
    check("bksp_buffer", digitos_value, 16'hF123);
    check("bksp_count", contagem, 3);
    check("bksp_ovf", overflow, 0);
    press_code(4'hD, 12);

    // Bounce rejection and long hold
    k0 = key_count;
    raw_low[0] = 1'b1; cyc(2);
    raw_low[0] = 1'b0; cyc(1);
    raw_low[0] = 1'b1; cyc(2);
    raw_low[0] = 1'b0; cyc(10);
    check("bounce_no_key", key_count - k0, 0);
    k0 = key_count;
    press_code(4'hF, 200);
    check("long_hold_one_key", key_count - k0, 1);

    // Timeout
    e0 = emit_count;
    press_code(4'h7, 12);
    for (int i = 0; i < 200 && emit_count == e0; i++) cyc(1);
    check("timeout_emit", emit_count - e0, 1);
    check("timeout_literal", last_msg, 16'hEEEE);
    cyc(2);
    check("timeout_cleared", contagem, 0);
    k0 = key_count; e0 = emit_count;
    cyc(1000);
    check("idle_no_emit", emit_count - e0, 0);
    check("idle_no_key", key_count - k0, 0);

    // Cancel and clear
    e0 = emit_count;
    press_code(4'h9, 12); press_code(4'h8, 12); press_code(4'hB, 12);
    check("cancel_emit", emit_count - e0, 1);
    check("cancel_msg", last_msg, 16'hBBBB);
    e0 = emit_count;
    press_code(4'h9, 12); press_code(4'hD, 12);
    check("clear_buffer", digitos_value, 16'hFFFF);
    check("clear_no_emit", emit_count - e0, 0);

    // Reset in DEBOUNCE
    press_code(4'h4, 12); press_code(4'h5, 12);
    press_map[1*NC+2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!lin_matriz[1]) found = 1'b1;
      else cyc(1);
    end
    check("reach_debounce", found, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_lin", lin_matriz, 4'hF);
    check("midrst_tecla_value", tecla_value, 4'hF);
    check("midrst_valids", {tecla_valid, digitos_valid}, 0);
    check("midrst_digitos", digitos_value, 16'hFFFF);
    check("midrst_count", {overflow, contagem}, 0);
    press_map = '0;
    cyc(3);
    rst = 1'b0;
    cyc(5);

    // Enable drop
    press_code(4'h1, 12); press_code(4'h2, 12);
    check("en_count_before", contagem, 2);
    k0 = key_count; e0 = emit_count;
    enable = 1'b0;
    cyc(3);
    check("en_buffer", digitos_value, 16'hFFFF);
    check("en_count", contagem, 0);
    check("en_lin", lin_matriz, 4'hF);
    check("en_no_pulse", (key_count - k0) + (emit_count - e0), 0);
    enable = 1'b1;
    cyc(5);

    // Two columns low together
    k0 = key_count;
    press_map[0] = 1'b1; press_map[1] = 1'b1;
    cyc(40);
    press_map = '0;
    cyc(10);
    check("two_cols_ignored", key_count - k0, 0);

    // Randomized keys against the model
    for (int i = 0; i < 40; i++) begin
      ri = $urandom_range(0, 3);
      ci = $urandom_range(0, 3);
      press_rc(ri, ci, $urandom_range(10, 20), $urandom_range(6, 14));
      if ($urandom_range(0, 5) == 0) cyc(60);
    end
    cyc(20);
    check("keys_outstanding", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
